llsc_reservation_unit: RTL and testbench

Responder side of the core's atomic-access interface. It tracks the single load-linked (LL) reservation and answers every memory request with an AtomicStatus. For SC, it decides PASS or FAIL and raises a store-commit strobe. It sits beside the data-cache port in MEM and watches external writes (snoop), squashes (flush) and an aging counter that invalidate the reservation.

---
 rtl/llsc_reservation_unit.sv | 168 ++++++++++++++++
 tb/tb_llsc_reservation_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/llsc_reservation_unit.sv
// ---------------------------------------------------------------------------
// llsc_reservation_unit
//
// Responder side of the core's atomic-access interface. Holds the single
// load-linked (LL) reservation, answers every accepted memory request one
// cycle later with an AtomicStatus, and decides PASS/FAIL for store-
// conditional (SC). External writes (snoop), pipeline squashes (flush) and
// an aging counter invalidate the reservation.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid             request this cycle (always accepted unless flushed)
//   req_access            0 = READ, 1 = WRITE
//   req_atomic            1 = LL (with READ) or SC (with WRITE)
//   req_addr              request byte address
//   snoop_valid/addr      external write observed this cycle
//   flush                 squash: kills this cycle's request and reservation
//   resp_valid            one-cycle response strobe
//   resp_status           0 = NOT_ATOMIC, 1 = ATOMIC_PASS, 2 = ATOMIC_FAIL
//   sc_commit             with resp_valid: SC may write memory
//   resv_valid/resv_addr  current reservation (low GRAN_BITS forced to 0)
// ---------------------------------------------------------------------------
module llsc_reservation_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int GRAN_BITS    = 2,
    parameter int RESV_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_access,
    input  logic                  req_atomic,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  snoop_valid,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [1:0]            resp_status,
    output logic                  sc_commit,
    output logic                  resv_valid,
    output logic [ADDR_WIDTH-1:0] resv_addr
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_RESERVED = 1'b1;

    localparam logic [1:0] NOT_ATOMIC  = 2'd0;
    localparam logic [1:0] ATOMIC_PASS = 2'd1;
    localparam logic [1:0] ATOMIC_FAIL = 2'd2;

    localparam logic ACC_READ  = 1'b0;
    localparam logic ACC_WRITE = 1'b1;

    localparam int              AGE_W     = (RESV_TIMEOUT > 0) ? $clog2(RESV_TIMEOUT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(RESV_TIMEOUT);
    localparam logic            EXPIRY_EN = (RESV_TIMEOUT != 0);

    // Clears the byte-within-granule bits so addresses compare by line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << GRAN_BITS) - ADDR_WIDTH'(1));

    // True when two byte addresses fall in the same reservation granule.
    function automatic logic same_line(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [ADDR_WIDTH-1:0] b);
        return ((a ^ b) & LINE_MASK) == {ADDR_WIDTH{1'b0}};
    endfunction

    logic [0:0]            state_r;
    logic [0:0]            state_nxt_s;
    logic [ADDR_WIDTH-1:0] resv_addr_r;
    logic [ADDR_WIDTH-1:0] resv_addr_nxt_s;
    logic [AGE_W-1:0]      age_r;
    logic [AGE_W-1:0]      age_nxt_s;
    logic                  resp_valid_r;
    logic [1:0]            resp_status_r;
    logic                  sc_commit_r;

    logic                  accept_s;
    logic                  is_ll_s;
    logic                  is_sc_s;
    logic                  is_store_s;
    logic                  held_s;
    logic                  req_hit_s;
    logic                  snoop_hit_s;
    logic                  expired_s;
    logic                  sc_pass_s;
    logic [1:0]            status_nxt_s;

    assign accept_s    = req_valid & ~flush;
    assign is_ll_s     = accept_s & (req_access == ACC_READ)  &  req_atomic;
    assign is_sc_s     = accept_s & (req_access == ACC_WRITE) &  req_atomic;
    assign is_store_s  = accept_s & (req_access == ACC_WRITE) & ~req_atomic;
    assign held_s      = (state_r == ST_RESERVED);
    assign req_hit_s   = held_s & same_line(req_addr, resv_addr_r);
    assign snoop_hit_s = held_s & snoop_valid & same_line(snoop_addr, resv_addr_r);
    assign expired_s   = held_s & EXPIRY_EN & (age_r == AGE_MAX);

    // An SC racing a snoop hit or an expired reservation must fail.
    assign sc_pass_s   = req_hit_s & ~snoop_hit_s & (~EXPIRY_EN | (age_r < AGE_MAX));

    // Response status for the request sampled this cycle.
    always_comb begin
        status_nxt_s = NOT_ATOMIC;
        case ({req_access, req_atomic})
            {ACC_READ, 1'b0}:  status_nxt_s = NOT_ATOMIC;
            {ACC_READ, 1'b1}:  status_nxt_s = ATOMIC_PASS;
            {ACC_WRITE, 1'b1}: status_nxt_s = sc_pass_s ? ATOMIC_PASS : ATOMIC_FAIL;
            default:           status_nxt_s = NOT_ATOMIC;
        endcase
    end

    // Reservation next-state: flush > LL > kill events > SC/store.
    always_comb begin
        state_nxt_s     = state_r;
        resv_addr_nxt_s = resv_addr_r;
        age_nxt_s       = age_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
            age_nxt_s   = {AGE_W{1'b0}};
        end else if (is_ll_s) begin
            // The snoop write is ordered before the LL, so the LL still wins.
            state_nxt_s     = ST_RESERVED;
            resv_addr_nxt_s = req_addr & LINE_MASK;
            age_nxt_s       = {AGE_W{1'b0}};
        end else if (snoop_hit_s | expired_s | is_sc_s | (is_store_s & req_hit_s)) begin
            state_nxt_s = ST_IDLE;
            age_nxt_s   = {AGE_W{1'b0}};
        end else if (held_s && EXPIRY_EN && (age_r != AGE_MAX)) begin
            age_nxt_s = age_r + AGE_W'(1);
        end else begin
            // Idle, or counter saturated / disabled: hold.
            age_nxt_s = age_r;
        end
    end

    // Reservation state, address and age registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            resv_addr_r <= {ADDR_WIDTH{1'b0}};
            age_r       <= {AGE_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            resv_addr_r <= resv_addr_nxt_s;
            age_r       <= age_nxt_s;
        end
    end

    // Registered one-cycle response; quiet (NOT_ATOMIC, no commit) otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r  <= 1'b0;
            resp_status_r <= NOT_ATOMIC;
            sc_commit_r   <= 1'b0;
        end else begin
            resp_valid_r  <= accept_s;
            resp_status_r <= accept_s ? status_nxt_s : NOT_ATOMIC;
            sc_commit_r   <= is_sc_s & sc_pass_s;
        end
    end

    assign resp_valid  = resp_valid_r;
    assign resp_status = resp_status_r;
    assign sc_commit   = sc_commit_r;
    assign resv_valid  = state_r;
    assign resv_addr   = resv_addr_r;

endmodule

// File: tb/tb_llsc_reservation_unit.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for llsc_reservation_unit. Three instances
// share the same stimulus: default timeout (u_def), RESV_TIMEOUT=4 (u_t4)
// and RESV_TIMEOUT=0 (u_t0). Inputs change #1 after a rising edge; outputs
// are read at that same point, i.e. after the edge that registered them.
// ---------------------------------------------------------------------------
module tb_llsc_reservation_unit;

    localparam logic [1:0] S_NA   = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_FL   = 2'd2;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_access, req_atomic;
    logic [31:0] req_addr;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic        flush;

    logic        d_rv, d_sc, d_vv;
    logic [1:0]  d_st;
    logic [31:0] d_ra;
    logic        f_rv, f_sc, f_vv;
    logic [1:0]  f_st;
    logic [31:0] f_ra;
    logic        z_rv, z_sc, z_vv;
    logic [1:0]  z_st;
    logic [31:0] z_ra;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    llsc_reservation_unit u_def (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_access(req_access),
        .req_atomic(req_atomic), .req_addr(req_addr), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .flush(flush), .resp_valid(d_rv),
        .resp_status(d_st), .sc_commit(d_sc), .resv_valid(d_vv), .resv_addr(d_ra));

    llsc_reservation_unit #(.RESV_TIMEOUT(4)) u_t4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_access(req_access),
        .req_atomic(req_atomic), .req_addr(req_addr), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .flush(flush), .resp_valid(f_rv),
        .resp_status(f_st), .sc_commit(f_sc), .resv_valid(f_vv), .resv_addr(f_ra));

    llsc_reservation_unit #(.RESV_TIMEOUT(0)) u_t0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_access(req_access),
        .req_atomic(req_atomic), .req_addr(req_addr), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .flush(flush), .resp_valid(z_rv),
        .resp_status(z_st), .sc_commit(z_sc), .resv_valid(z_vv), .resv_addr(z_ra));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid = 1'b0; req_access = RD; req_atomic = 1'b0; req_addr = 32'h0;
        snoop_valid = 1'b0; snoop_addr = 32'h0; flush = 1'b0;
    endtask

    task automatic set_req(input logic acc, input logic atom, input logic [31:0] addr);
        clear_in();
        req_valid = 1'b1; req_access = acc; req_atomic = atom; req_addr = addr;
    endtask

    task automatic do_reset();
        clear_in(); rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset asserted together with an LL: reset must win.
        set_req(RD, 1'b1, 32'h1234); rst = 1'b1; cyc(); rst = 1'b0; clear_in();
        checks++; if (d_rv !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b exp 0", d_rv); end
        checks++; if (d_st !== S_NA) begin errors++; $display("FAIL reset_status: got %0d exp 0", d_st); end
        checks++; if (d_sc !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0b exp 0", d_sc); end
        checks++; if (d_vv !== 1'b0) begin errors++; $display("FAIL reset_resv_valid: got %0b exp 0", d_vv); end
        checks++; if (d_ra !== 32'h0) begin errors++; $display("FAIL reset_resv_addr: got %h exp 0", d_ra); end
    endtask

    task automatic test_ll_sc();
        do_reset();
        set_req(RD, 1'b1, 32'h1000); cyc(); clear_in();
        checks++; if (d_rv !== 1'b1 || d_st !== S_PASS || d_sc !== 1'b0) begin errors++; $display("FAIL ll_resp: got v=%0b st=%0d c=%0b exp v=1 st=1 c=0", d_rv, d_st, d_sc); end
        checks++; if (d_vv !== 1'b1 || d_ra !== 32'h1000) begin errors++; $display("FAIL ll_resv: got v=%0b a=%h exp v=1 a=00001000", d_vv, d_ra); end
        cyc();
        checks++; if (d_rv !== 1'b0 || d_st !== S_NA) begin errors++; $display("FAIL idle_quiet: got v=%0b st=%0d exp v=0 st=0", d_rv, d_st); end
        cyc(); cyc();
        set_req(WR, 1'b1, 32'h1000); cyc(); clear_in();
        checks++; if (d_rv !== 1'b1 || d_st !== S_PASS || d_sc !== 1'b1) begin errors++; $display("FAIL sc_pass: got v=%0b st=%0d c=%0b exp v=1 st=1 c=1", d_rv, d_st, d_sc); end
        checks++; if (d_vv !== 1'b0) begin errors++; $display("FAIL sc_clears_resv: got %0b exp 0", d_vv); end
    endtask

    task automatic test_snoop();
        do_reset();
        set_req(RD, 1'b1, 32'h1000); cyc();
        clear_in(); snoop_valid = 1'b1; snoop_addr = 32'h1002; cyc(); clear_in();
        checks++; if (d_vv !== 1'b0) begin errors++; $display("FAIL snoop_same_word_kill: got %0b exp 0", d_vv); end
        set_req(WR, 1'b1, 32'h1000); cyc(); clear_in();
        checks++; if (d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL snoop_hit_sc: got st=%0d c=%0b exp st=2 c=0", d_st, d_sc); end
        set_req(RD, 1'b1, 32'h1000); cyc();
        clear_in(); snoop_valid = 1'b1; snoop_addr = 32'h1004; cyc(); clear_in();
        set_req(WR, 1'b1, 32'h1000); cyc(); clear_in();
        checks++; if (d_st !== S_PASS || d_sc !== 1'b1) begin errors++; $display("FAIL snoop_miss_sc: got st=%0d c=%0b exp st=1 c=1", d_st, d_sc); end
        // Snoop hit in the very same cycle as the SC.
        set_req(RD, 1'b1, 32'h1000); cyc();
        set_req(WR, 1'b1, 32'h1000); snoop_valid = 1'b1; snoop_addr = 32'h1001; cyc(); clear_in();
        checks++; if (d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL sc_with_snoop: got st=%0d c=%0b exp st=2 c=0", d_st, d_sc); end
    endtask

    task automatic test_store();
        do_reset();
        set_req(RD, 1'b1, 32'h2000); cyc();
        set_req(WR, 1'b0, 32'h2000); cyc(); clear_in();
        checks++; if (d_rv !== 1'b1 || d_st !== S_NA || d_sc !== 1'b0) begin errors++; $display("FAIL store_resp: got v=%0b st=%0d c=%0b exp v=1 st=0 c=0", d_rv, d_st, d_sc); end
        checks++; if (d_vv !== 1'b0) begin errors++; $display("FAIL store_hit_kill: got %0b exp 0", d_vv); end
        set_req(WR, 1'b1, 32'h2000); cyc(); clear_in();
        checks++; if (d_st !== S_FL) begin errors++; $display("FAIL sc_after_store: got %0d exp 2", d_st); end
        set_req(RD, 1'b1, 32'h2000); cyc();
        set_req(WR, 1'b0, 32'h3000); cyc();
        checks++; if (d_vv !== 1'b1) begin errors++; $display("FAIL store_miss_keep: got %0b exp 1", d_vv); end
        set_req(RD, 1'b0, 32'h2000); cyc();
        checks++; if (d_rv !== 1'b1 || d_st !== S_NA || d_vv !== 1'b1) begin errors++; $display("FAIL plain_read: got v=%0b st=%0d rv=%0b exp v=1 st=0 rv=1", d_rv, d_st, d_vv); end
        set_req(WR, 1'b1, 32'h2000); cyc(); clear_in();
        checks++; if (d_st !== S_PASS || d_sc !== 1'b1) begin errors++; $display("FAIL sc_after_miss_store: got st=%0d c=%0b exp st=1 c=1", d_st, d_sc); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(RD, 1'b1, 32'h40); cyc(); clear_in();
        repeat (4) cyc();
        set_req(WR, 1'b1, 32'h40); cyc(); clear_in();
        checks++; if (f_st !== S_FL || f_sc !== 1'b0) begin errors++; $display("FAIL t4_wait4: got st=%0d c=%0b exp st=2 c=0", f_st, f_sc); end
        set_req(RD, 1'b1, 32'h40); cyc(); clear_in();
        repeat (2) cyc();
        set_req(WR, 1'b1, 32'h40); cyc(); clear_in();
        checks++; if (f_st !== S_PASS || f_sc !== 1'b1) begin errors++; $display("FAIL t4_wait2: got st=%0d c=%0b exp st=1 c=1", f_st, f_sc); end
        set_req(RD, 1'b1, 32'h40); cyc(); clear_in();
        repeat (5000) cyc();
        checks++; if (z_vv !== 1'b1 || f_vv !== 1'b0 || d_vv !== 1'b0) begin errors++; $display("FAIL long_wait_resv: got t0=%0b t4=%0b def=%0b exp 1 0 0", z_vv, f_vv, d_vv); end
        set_req(WR, 1'b1, 32'h40); cyc(); clear_in();
        checks++; if (z_st !== S_PASS || z_sc !== 1'b1) begin errors++; $display("FAIL t0_no_expiry: got st=%0d c=%0b exp st=1 c=1", z_st, z_sc); end
        checks++; if (d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL def_expired: got st=%0d c=%0b exp st=2 c=0", d_st, d_sc); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(RD, 1'b1, 32'h1000); cyc();
        set_req(WR, 1'b1, 32'h1000); flush = 1'b1; cyc(); clear_in();
        checks++; if (d_rv !== 1'b0 || d_sc !== 1'b0 || d_vv !== 1'b0) begin errors++; $display("FAIL flushed_sc: got v=%0b c=%0b rv=%0b exp 0 0 0", d_rv, d_sc, d_vv); end
        set_req(RD, 1'b1, 32'h1000); cyc();
        clear_in(); flush = 1'b1; cyc(); clear_in();
        checks++; if (d_rv !== 1'b0 || d_vv !== 1'b0) begin errors++; $display("FAIL bare_flush: got v=%0b rv=%0b exp 0 0", d_rv, d_vv); end
        set_req(RD, 1'b1, 32'h80); snoop_valid = 1'b1; snoop_addr = 32'h80; cyc(); clear_in();
        checks++; if (d_vv !== 1'b1 || d_ra !== 32'h80 || d_st !== S_PASS) begin errors++; $display("FAIL ll_with_snoop: got rv=%0b a=%h st=%0d exp 1 00000080 1", d_vv, d_ra, d_st); end
        set_req(WR, 1'b1, 32'h80); cyc(); clear_in();
        checks++; if (d_st !== S_PASS || d_sc !== 1'b1) begin errors++; $display("FAIL sc_after_ll_snoop: got st=%0d c=%0b exp 1 1", d_st, d_sc); end
        do_reset();
        set_req(WR, 1'b1, 32'h1000); cyc(); clear_in();
        checks++; if (d_rv !== 1'b1 || d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL sc_no_ll: got v=%0b st=%0d c=%0b exp 1 2 0", d_rv, d_st, d_sc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(RD, 1'b1, 32'h103); cyc();
        checks++; if (d_st !== S_PASS || d_ra !== 32'h100) begin errors++; $display("FAIL b2b_ll: got st=%0d a=%h exp 1 00000100", d_st, d_ra); end
        set_req(WR, 1'b1, 32'h101); cyc();
        checks++; if (d_rv !== 1'b1 || d_st !== S_PASS || d_sc !== 1'b1) begin errors++; $display("FAIL b2b_sc1: got v=%0b st=%0d c=%0b exp 1 1 1", d_rv, d_st, d_sc); end
        set_req(WR, 1'b1, 32'h100); cyc();
        checks++; if (d_rv !== 1'b1 || d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL b2b_sc2: got v=%0b st=%0d c=%0b exp 1 2 0", d_rv, d_st, d_sc); end
        set_req(RD, 1'b0, 32'h100); cyc(); clear_in();
        checks++; if (d_rv !== 1'b1 || d_st !== S_NA) begin errors++; $display("FAIL b2b_read: got v=%0b st=%0d exp 1 0", d_rv, d_st); end
        cyc();
        checks++; if (d_rv !== 1'b0) begin errors++; $display("FAIL b2b_single_strobe: got %0b exp 0", d_rv); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(RD, 1'b1, 32'h500); cyc();
        set_req(WR, 1'b1, 32'h500); rst = 1'b1; cyc(); rst = 1'b0; clear_in();
        checks++; if (d_rv !== 1'b0 || d_vv !== 1'b0 || d_ra !== 32'h0) begin errors++; $display("FAIL mid_reset: got v=%0b rv=%0b a=%h exp 0 0 0", d_rv, d_vv, d_ra); end
        set_req(WR, 1'b1, 32'h500); cyc(); clear_in();
        checks++; if (d_st !== S_FL || d_sc !== 1'b0) begin errors++; $display("FAIL sc_after_reset: got st=%0d c=%0b exp 2 0", d_st, d_sc); end
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        test_reset();
        test_ll_sc();
        test_snoop();
        test_store();
        test_timeout();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
